sap_u_control_sequencer: RTL and testbench
==========================================

// Module: sap_u_control_sequencer
// PURPOSE
//   Microcoded control unit for the SAP-U datapath, directly upstream of the A/B registers, ALU and RAM.
//   A T-state step counter and the IR opcode produce the full control word each cycle.
//   The control word drives the bus enables, register loads, ALU enable/subtract, and the RAM/MAR strobes.
//   Fetch is T0-T1. Execute is T2-T4. A HLT opcode freezes the machine until reset.
// PARAMETERS
//   T_STATES  5  steps per instruction (legal 5..8); steps >=5 emit the idle word
//   OPCODE_W  4  width of ir_opcode
// PORTS
//   clk                 in   1  system clock; all state changes on posedge
//   reset               in   1  asynchronous, active-high; clears step counter and halted
//   ir_opcode           in   4  upper nibble of the instruction register; valid from T2
//   step                out  3  current T-state (debug)
//   halted              out  1  high after HLT executes; high only in halted state
//   pc_count_en         out  1  active-high: PC increments at the next edge
//   pc_bus_enable_n     out  1  active-low: PC drives the bus
//   pc_load_n           out  1  active-low: PC loads from the bus (jump)
//   ram_load_mar_reg    out  1  active-low: MAR loads from the bus
//   ram_output_enable   out  1  active-low: RAM drives the bus
//   ram_control_signal  out  1  active-high: RAM writes the bus value
//   ir_load_n           out  1  active-low: IR loads from the bus
//   ir_bus_enable_n     out  1  active-low: IR low nibble drives the bus
//   reg_a_load_n        out  1  active-low: A loads from the bus
//   reg_a_bus_enable_n  out  1  active-low: A drives the bus
//   reg_b_load_n        out  1  active-low: B loads from the bus
//   reg_b_bus_enable_n  out  1  active-low: B drives the bus
//   alu_enable          out  1  active-high: ALU drives the bus
//   alu_subtract        out  1  1 = A-B, 0 = A+B
//   out_load_n          out  1  active-low: output register loads from the bus
// BEHAVIOUR
//   - Idle word: every *_n output = 1, ram_load_mar_reg = 1, ram_output_enable = 1, every active-high output = 0.
//   - Reset (async, any time, including mid-instruction): step = 0, halted = 0.
//     Outputs immediately show the T0 word. There is no partial-instruction completion.
//   - Step counter: increments on each posedge. Wraps T_STATES-1 -> 0. Holds at 0 while halted.
//   - Control word: combinational from (step, ir_opcode, halted). It is stable for the whole cycle.
//     Datapath elements act on the posedge that ends the step.
//   - Fetch, all opcodes:
//     - T0: pc_bus_enable_n = 0, ram_load_mar_reg = 0.
//     - T1: ram_output_enable = 0, ir_load_n = 0, pc_count_en = 1.
//   - Execute, T2/T3/T4 (unlisted steps emit the idle word):
//     - 0 NOP: idle.
//     - 1 LDA: T2 ir_bus_enable_n = 0 + ram_load_mar_reg = 0; T3 ram_output_enable = 0 + reg_a_load_n = 0.
//     - 2 ADD: T2 as LDA; T3 ram_output_enable = 0 + reg_b_load_n = 0; T4 alu_enable = 1 + reg_a_load_n = 0.
//     - 3 SUB: as ADD, plus alu_subtract = 1 during T3 and T4.
//     - 4 STA: T2 as LDA; T3 reg_a_bus_enable_n = 0 + ram_control_signal = 1.
//     - 5 LDI: T2 ir_bus_enable_n = 0 + reg_a_load_n = 0.
//     - 6 JMP: T2 ir_bus_enable_n = 0 + pc_load_n = 0.
//     - E OUT: T2 reg_a_bus_enable_n = 0 + out_load_n = 0.
//     - F HLT: T2 emits idle; at the T2->T3 edge, halted <= 1 and step <= 0.
//     - 7-D: treated as NOP.
//   - Halted: the idle word is forced every cycle; ir_opcode is ignored. Only reset exits this state.
//   - Invariant: at most one bus driver active per cycle (pc/ram/ir/reg_a/reg_b/alu).
// TESTING
//   - Reset asserted mid-T3 of ADD -> step = 0 asynchronously; the T0 word appears the same cycle; halted = 0.
//   - NOP loop for 10 cycles -> step sequence 0,1,2,3,4,0,...; pc_count_en high only in T1.
//   - Opcode 3 (SUB) -> T4: alu_enable = 1, alu_subtract = 1, reg_a_load_n = 0; all other drivers idle.
//   - Opcode 4 (STA) -> T3: reg_a_bus_enable_n = 0, ram_control_signal = 1; T4 is idle.
//   - Opcode F (HLT) -> halted = 1 after the T2 edge. Step stays 0 and the idle word holds for 20 cycles,
//     even if ir_opcode changes. Reset clears.
//   - Bus check, every opcode 0-F x every step -> no more than one *_bus_enable_n/ram_output_enable low or
//     alu_enable high.

Source files
------------

// File: rtl/sap_u_control_sequencer.sv
// SAP-U microcoded control unit: a T-state counter plus the IR opcode select the
// control word that steers the bus, register loads, ALU and RAM each cycle.
module sap_u_control_sequencer #(
  parameter int T_STATES = 5,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] ir_opcode,
  output logic [2:0]          step,
  output logic                halted,
  output logic                pc_count_en,
  output logic                pc_bus_enable_n,
  output logic                pc_load_n,
  output logic                ram_load_mar_reg,
  output logic                ram_output_enable,
  output logic                ram_control_signal,
  output logic                ir_load_n,
  output logic                ir_bus_enable_n,
  output logic                reg_a_load_n,
  output logic                reg_a_bus_enable_n,
  output logic                reg_b_load_n,
  output logic                reg_b_bus_enable_n,
  output logic                alu_enable,
  output logic                alu_subtract,
  output logic                out_load_n
);

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;
  localparam logic [2:0] LAST_STEP = 3'(T_STATES - 1);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  logic [2:0] step_q, step_d;
  logic       halted_q, halted_d;

  // HLT is taken on the edge that ends T2; once halted the counter parks at T0.
  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      step_d = T0;
    end else if (step_q == T2 && ir_opcode == OP_HLT) begin
      halted_d = 1'b1;
      step_d   = T0;
    end else if (step_q == LAST_STEP) begin
      step_d = T0;
    end else begin
      step_d = step_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign step   = step_q;
  assign halted = halted_q;

  always_comb begin
    pc_count_en        = 1'b0;
    pc_bus_enable_n    = 1'b1;
    pc_load_n          = 1'b1;
    ram_load_mar_reg   = 1'b1;
    ram_output_enable  = 1'b1;
    ram_control_signal = 1'b0;
    ir_load_n          = 1'b1;
    ir_bus_enable_n    = 1'b1;
    reg_a_load_n       = 1'b1;
    reg_a_bus_enable_n = 1'b1;
    reg_b_load_n       = 1'b1;
    reg_b_bus_enable_n = 1'b1;
    alu_enable         = 1'b0;
    alu_subtract       = 1'b0;
    out_load_n         = 1'b1;
    if (!halted_q) begin
      case (step_q)
        T0: begin
          pc_bus_enable_n  = 1'b0;
          ram_load_mar_reg = 1'b0;
        end
        T1: begin
          ram_output_enable = 1'b0;
          ir_load_n         = 1'b0;
          pc_count_en       = 1'b1;
        end
        T2: begin
          case (ir_opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_bus_enable_n  = 1'b0;
              ram_load_mar_reg = 1'b0;
            end
            OP_LDI: begin
              ir_bus_enable_n = 1'b0;
              reg_a_load_n    = 1'b0;
            end
            OP_JMP: begin
              ir_bus_enable_n = 1'b0;
              pc_load_n       = 1'b0;
            end
            OP_OUT: begin
              reg_a_bus_enable_n = 1'b0;
              out_load_n         = 1'b0;
            end
            default: ;
          endcase
        end
        T3: begin
          case (ir_opcode)
            OP_LDA: begin
              ram_output_enable = 1'b0;
              reg_a_load_n      = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              ram_output_enable = 1'b0;
              reg_b_load_n      = 1'b0;
              alu_subtract      = (ir_opcode == OP_SUB);
            end
            OP_STA: begin
              reg_a_bus_enable_n = 1'b0;
              ram_control_signal = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
            alu_enable   = 1'b1;
            reg_a_load_n = 1'b0;
            alu_subtract = (ir_opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sap_u_control_sequencer.sv
// Self-checking bench for sap_u_control_sequencer: directed phases plus random
// opcode/reset traffic compared against a microprogram-table reference model.
module tb_sap_u_control_sequencer;

  localparam int T_STATES = 5;

  localparam logic [14:0] M_PC_CNT   = 15'h4000;
  localparam logic [14:0] M_PC_BUS   = 15'h2000;
  localparam logic [14:0] M_PC_LOAD  = 15'h1000;
  localparam logic [14:0] M_MAR      = 15'h0800;
  localparam logic [14:0] M_RAM_OE   = 15'h0400;
  localparam logic [14:0] M_RAM_WR   = 15'h0200;
  localparam logic [14:0] M_IR_LOAD  = 15'h0100;
  localparam logic [14:0] M_IR_BUS   = 15'h0080;
  localparam logic [14:0] M_A_LOAD   = 15'h0040;
  localparam logic [14:0] M_A_BUS    = 15'h0020;
  localparam logic [14:0] M_B_LOAD   = 15'h0010;
  localparam logic [14:0] M_B_BUS    = 15'h0008;
  localparam logic [14:0] M_ALU_EN   = 15'h0004;
  localparam logic [14:0] M_ALU_SUB  = 15'h0002;
  localparam logic [14:0] M_OUT_LOAD = 15'h0001;
  localparam logic [14:0] LOW_MASK   = M_PC_BUS | M_PC_LOAD | M_MAR | M_RAM_OE | M_IR_LOAD |
                                       M_IR_BUS | M_A_LOAD | M_A_BUS | M_B_LOAD | M_B_BUS |
                                       M_OUT_LOAD;

  logic       clk;
  logic       reset;
  logic [3:0] ir_opcode;
  logic [2:0] step;
  logic       halted;
  logic       pc_count_en, pc_bus_enable_n, pc_load_n, ram_load_mar_reg, ram_output_enable;
  logic       ram_control_signal, ir_load_n, ir_bus_enable_n, reg_a_load_n, reg_a_bus_enable_n;
  logic       reg_b_load_n, reg_b_bus_enable_n, alu_enable, alu_subtract, out_load_n;

  int vectors = 0;
  int miscompares = 0;
  int m_step = 0;
  bit m_halted = 1'b0;
  logic [14:0] uprog [16][3];

  sap_u_control_sequencer #(.T_STATES(T_STATES), .OPCODE_W(4)) dut (
    .clk(clk), .reset(reset), .ir_opcode(ir_opcode), .step(step), .halted(halted),
    .pc_count_en(pc_count_en), .pc_bus_enable_n(pc_bus_enable_n), .pc_load_n(pc_load_n),
    .ram_load_mar_reg(ram_load_mar_reg), .ram_output_enable(ram_output_enable),
    .ram_control_signal(ram_control_signal), .ir_load_n(ir_load_n),
    .ir_bus_enable_n(ir_bus_enable_n), .reg_a_load_n(reg_a_load_n),
    .reg_a_bus_enable_n(reg_a_bus_enable_n), .reg_b_load_n(reg_b_load_n),
    .reg_b_bus_enable_n(reg_b_bus_enable_n), .alu_enable(alu_enable),
    .alu_subtract(alu_subtract), .out_load_n(out_load_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference machine state advances on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_step   = 0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_step = 0;
    end else if (m_step == 2 && ir_opcode == 4'hF) begin
      m_halted = 1'b1;
      m_step   = 0;
    end else begin
      m_step = (m_step + 1) % T_STATES;
    end
  end

  function automatic logic [14:0] expectedActive(input int s, input int op, input bit h);
    if (h) return 15'h0;
    if (s == 0) return M_PC_BUS | M_MAR;
    if (s == 1) return M_RAM_OE | M_IR_LOAD | M_PC_CNT;
    if (s >= 2 && s <= 4) return uprog[op][s-2];
    return 15'h0;
  endfunction

  task automatic checkOutput(input string tag);
    logic [14:0] exp_pins;
    logic [14:0] act_pins;
    int drivers;
    exp_pins = expectedActive(m_step, int'(ir_opcode), m_halted) ^ LOW_MASK;
    act_pins = {pc_count_en, pc_bus_enable_n, pc_load_n, ram_load_mar_reg, ram_output_enable,
                ram_control_signal, ir_load_n, ir_bus_enable_n, reg_a_load_n, reg_a_bus_enable_n,
                reg_b_load_n, reg_b_bus_enable_n, alu_enable, alu_subtract, out_load_n};
    drivers = int'(!pc_bus_enable_n) + int'(!ram_output_enable) + int'(!ir_bus_enable_n) +
              int'(!reg_a_bus_enable_n) + int'(!reg_b_bus_enable_n) + int'(alu_enable);
    vectors++;
    assert (step === 3'(m_step)) else begin
      miscompares++;
      $error("[TB] FAIL %s step: observed %0d expected %0d", tag, step, m_step);
    end
    vectors++;
    assert (halted === m_halted) else begin
      miscompares++;
      $error("[TB] FAIL %s halted: observed %0b expected %0b", tag, halted, m_halted);
    end
    vectors++;
    assert (act_pins === exp_pins) else begin
      miscompares++;
      $error("[TB] FAIL %s word (op %h): observed %b expected %b", tag, ir_opcode, act_pins, exp_pins);
    end
    vectors++;
    assert (drivers <= 1) else begin
      miscompares++;
      $error("[TB] FAIL %s bus_drivers: observed %0d expected <=1", tag, drivers);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op);
    ir_opcode = op;
  endtask

  task automatic clockCycle(input string tag);
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input string tag);
    reset    = 1'b1;
    m_step   = 0;
    m_halted = 1'b0;
    #1;
    checkOutput(tag);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    for (int o = 0; o < 16; o++)
      for (int s = 0; s < 3; s++) uprog[o][s] = 15'h0;
    uprog[1][0] = M_IR_BUS | M_MAR;   uprog[1][1] = M_RAM_OE | M_A_LOAD;
    uprog[2][0] = M_IR_BUS | M_MAR;   uprog[2][1] = M_RAM_OE | M_B_LOAD;
    uprog[2][2] = M_ALU_EN | M_A_LOAD;
    uprog[3][0] = M_IR_BUS | M_MAR;   uprog[3][1] = M_RAM_OE | M_B_LOAD | M_ALU_SUB;
    uprog[3][2] = M_ALU_EN | M_A_LOAD | M_ALU_SUB;
    uprog[4][0] = M_IR_BUS | M_MAR;   uprog[4][1] = M_A_BUS | M_RAM_WR;
    uprog[5][0] = M_IR_BUS | M_A_LOAD;
    uprog[6][0] = M_IR_BUS | M_PC_LOAD;
    uprog[14][0] = M_A_BUS | M_OUT_LOAD;

    ir_opcode = 4'h0;
    reset = 1'b1;
    #2;
    checkOutput("por");
    #1;
    reset = 1'b0;

    // NOP loop: step walks 0..4 and wraps
    for (int i = 0; i < 10; i++) clockCycle("nop_loop");

    // Async reset in the middle of ADD T3
    applyReset("pre_add");
    applyStimulus(4'h2);
    for (int i = 0; i < 3; i++) clockCycle("add_fetch");
    @(negedge clk);
    checkOutput("add_t3");
    #1;
    applyReset("add_mid_reset");
    for (int i = 0; i < 5; i++) clockCycle("after_reset");

    // Every opcode through every step, fresh reset before each
    for (int op = 0; op < 16; op++) begin
      applyReset("sweep_reset");
      applyStimulus(4'(op));
      for (int i = 0; i < T_STATES + 1; i++) clockCycle("sweep");
    end

    // HLT freezes for 20 cycles even with opcode churn
    applyReset("hlt_reset");
    applyStimulus(4'hF);
    for (int i = 0; i < 3; i++) clockCycle("hlt_entry");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'($urandom_range(0, 15)));
      clockCycle("halted_hold");
    end
    applyReset("hlt_exit");
    clockCycle("post_hlt");

    // Random opcode changes and occasional async resets
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) applyReset("rand_reset");
      if ($urandom_range(0, 3) == 0) applyStimulus(4'($urandom_range(0, 15)));
      clockCycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
